// File: rtl/softmax_exp_input_scheduler_if.sv
// Handshake and operand bus between the softmax exp-input scheduler and its neighbours.
// The master modport is the scheduler. The slave modport is the control/datapath side.
interface softmax_exp_input_scheduler_if #(
  parameter int DATA_WIDTH = 32,
  parameter int N_INPUTS   = 10
);
  localparam int G  = (N_INPUTS + 3) / 4;
  localparam int GW = (G > 1) ? $clog2(G) : 1;

  logic                           start;
  logic [N_INPUTS*DATA_WIDTH-1:0] in_vector;
  logic                           exp_ready;
  logic                           dp_done;
  logic                           busy;
  logic                           dp_enable;
  logic [DATA_WIDTH-1:0]          dp_in1;
  logic [DATA_WIDTH-1:0]          dp_in2;
  logic [DATA_WIDTH-1:0]          dp_in3;
  logic [DATA_WIDTH-1:0]          dp_in4;
  logic [DATA_WIDTH-1:0]          dp_max;
  logic [3:0]                     lane_valid;
  logic [GW-1:0]                  group_idx;
  logic                           last_group;
  logic                           done;

  modport master (
    input  start, in_vector, exp_ready, dp_done,
    output busy, dp_enable, dp_in1, dp_in2, dp_in3, dp_in4, dp_max,
           lane_valid, group_idx, last_group, done
  );

  modport slave (
    output start, in_vector, exp_ready, dp_done,
    input  busy, dp_enable, dp_in1, dp_in2, dp_in3, dp_in4, dp_max,
           lane_valid, group_idx, last_group, done
  );
endinterface

// File: rtl/softmax_exp_input_scheduler.sv
// Softmax exp-input sequencer: multi-cycle vector max, then issues groups of four
// operands plus the max to the "max minus x" datapath, one group per handshake.
//
// state   | meaning
// --------+------------------------------------------------------------
// S_IDLE  | waiting for start; vector captured on accepted start
// S_MAX   | one group per cycle folded into the running max
// S_ISSUE | group operands registered; pulse dp_enable once exp_ready=1
// S_WAIT  | operands held until the datapath returns dp_done
// S_DONE  | one-cycle done pulse
module softmax_exp_input_scheduler #(
  parameter int ARITH_TYPE = 0,
  parameter int DATA_WIDTH = 32,
  parameter int E          = 8,
  parameter int M          = 23,
  parameter int N_INPUTS   = 10
) (
  input logic                          clk,
  input logic                          reset,
  softmax_exp_input_scheduler_if.master bus
);
  localparam int G  = (N_INPUTS + 3) / 4;
  localparam int GW = (G > 1) ? $clog2(G) : 1;
  localparam logic [GW-1:0] LAST_GRP = GW'(G - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_MAX,
    S_ISSUE,
    S_WAIT,
    S_DONE
  } state_t;

  state_t state, state_nxt;

  logic [DATA_WIDTH-1:0] vec_q [N_INPUTS];
  logic [DATA_WIDTH-1:0] run_max_q;
  logic [DATA_WIDTH-1:0] max_nxt;
  logic [DATA_WIDTH-1:0] pad_val;
  logic [GW-1:0]         grp_q;
  logic [GW-1:0]         load_grp;
  logic                  load_issue;
  logic [DATA_WIDTH-1:0] ld_op [4];
  logic [3:0]            ld_valid;

  logic [DATA_WIDTH-1:0] dp_in_q [4];
  logic [DATA_WIDTH-1:0] dp_max_q;
  logic [3:0]            lane_valid_q;
  logic [GW-1:0]         group_idx_q;
  logic                  last_group_q;

  // Strict "a greater than b"; +0/-0 are equal so a tie never replaces the running max.
  function automatic logic gt(input logic [DATA_WIDTH-1:0] a, input logic [DATA_WIDTH-1:0] b);
    logic [E+M-1:0] ma, mb;
    ma = a[E+M-1:0];
    mb = b[E+M-1:0];
    if (ARITH_TYPE == 1) return $signed(a) > $signed(b);
    if (ma == '0 && mb == '0) return 1'b0;
    if (a[DATA_WIDTH-1] != b[DATA_WIDTH-1]) return ~a[DATA_WIDTH-1];
    if (!a[DATA_WIDTH-1]) return ma > mb;
    return ma < mb;
  endfunction

  always_comb begin
    max_nxt = run_max_q;
    for (int l = 0; l < 4; l++) begin
      for (int k = 0; k < N_INPUTS; k++) begin
        if (k == int'(grp_q) * 4 + l && gt(vec_q[k], max_nxt)) max_nxt = vec_q[k];
      end
    end
  end

  // Leaving MAX, the max register is loaded on the same edge, so pad from max_nxt.
  assign pad_val    = (state == S_MAX) ? max_nxt : dp_max_q;
  assign load_grp   = (state == S_MAX) ? '0 : grp_q + 1'b1;
  assign load_issue = ((state == S_MAX) && (grp_q == LAST_GRP)) ||
                      ((state == S_WAIT) && bus.dp_done && !last_group_q);

  always_comb begin
    for (int l = 0; l < 4; l++) begin
      ld_valid[l] = 1'b0;
      ld_op[l]    = pad_val;
      for (int k = 0; k < N_INPUTS; k++) begin
        if (k == int'(load_grp) * 4 + l) begin
          ld_valid[l] = 1'b1;
          ld_op[l]    = vec_q[k];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:  if (bus.start) state_nxt = S_MAX;
      S_MAX:   if (grp_q == LAST_GRP) state_nxt = S_ISSUE;
      S_ISSUE: if (bus.exp_ready) state_nxt = S_WAIT;
      S_WAIT:  if (bus.dp_done) state_nxt = last_group_q ? S_DONE : S_ISSUE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < N_INPUTS; k++) vec_q[k] <= '0;
      for (int l = 0; l < 4; l++) dp_in_q[l] <= '0;
      run_max_q    <= '0;
      grp_q        <= '0;
      dp_max_q     <= '0;
      lane_valid_q <= '0;
      group_idx_q  <= '0;
      last_group_q <= 1'b0;
    end else begin
      if (state == S_IDLE && bus.start) begin
        for (int k = 0; k < N_INPUTS; k++)
          vec_q[k] <= bus.in_vector[k*DATA_WIDTH +: DATA_WIDTH];
        run_max_q <= bus.in_vector[DATA_WIDTH-1:0];
        grp_q     <= '0;
      end
      if (state == S_MAX) begin
        run_max_q <= max_nxt;
        if (grp_q == LAST_GRP) dp_max_q <= max_nxt;
      end
      if (state == S_MAX && grp_q != LAST_GRP) grp_q <= grp_q + 1'b1;
      if (load_issue) begin
        grp_q <= load_grp;
        for (int l = 0; l < 4; l++) dp_in_q[l] <= ld_op[l];
        lane_valid_q <= ld_valid;
        group_idx_q  <= load_grp;
        last_group_q <= (load_grp == LAST_GRP);
      end
    end
  end

  assign bus.busy       = (state != S_IDLE);
  assign bus.dp_enable  = (state == S_ISSUE) && bus.exp_ready;
  assign bus.done       = (state == S_DONE);
  assign bus.dp_in1     = dp_in_q[0];
  assign bus.dp_in2     = dp_in_q[1];
  assign bus.dp_in3     = dp_in_q[2];
  assign bus.dp_in4     = dp_in_q[3];
  assign bus.dp_max     = dp_max_q;
  assign bus.lane_valid = lane_valid_q;
  assign bus.group_idx  = group_idx_q;
  assign bus.last_group = last_group_q;
endmodule

// File: tb/tb_softmax_exp_input_scheduler.sv
// Bench for softmax_exp_input_scheduler: float N=10 instance and fixed-point N=4 instance,
// each cycle checked against a schedule and max computed from plain arithmetic.
module tb_softmax_exp_input_scheduler;
  localparam int N  = 10;
  localparam int G  = 3;
  localparam int NF = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  softmax_exp_input_scheduler_if #(.DATA_WIDTH(32), .N_INPUTS(N))  bus0 ();
  softmax_exp_input_scheduler_if #(.DATA_WIDTH(32), .N_INPUTS(NF)) bus1 ();

  softmax_exp_input_scheduler #(.ARITH_TYPE(0), .DATA_WIDTH(32), .E(8), .M(23), .N_INPUTS(N))
    dut0 (.clk(clk), .reset(reset), .bus(bus0.master));
  softmax_exp_input_scheduler #(.ARITH_TYPE(1), .DATA_WIDTH(32), .E(8), .M(23), .N_INPUTS(NF))
    dut1 (.clk(clk), .reset(reset), .bus(bus1.master));

  int total = 0;
  int bad   = 0;
  logic [31:0] tv [N];
  logic [31:0] tf [NF];

  // Float ordering key: signed magnitude as an integer, so -0 and +0 map to the same key.
  function automatic longint fkey(input logic [31:0] x);
    longint mag;
    mag = longint'(x[30:0]);
    return x[31] ? -mag : mag;
  endfunction

  function automatic logic [31:0] model_fmax();
    logic [31:0] best;
    best = tv[0];
    for (int k = 1; k < N; k++) if (fkey(tv[k]) > fkey(best)) best = tv[k];
    return best;
  endfunction

  function automatic logic [31:0] model_smax();
    logic [31:0] best;
    best = tf[0];
    for (int k = 1; k < NF; k++) if ($signed(tf[k]) > $signed(best)) best = tf[k];
    return best;
  endfunction

  function automatic logic [31:0] rand_float();
    logic [7:0]  ex;
    logic [22:0] mant;
    logic        s;
    s    = 1'($urandom_range(0, 1));
    ex   = 8'($urandom_range(0, 254));
    mant = 23'($urandom);
    return {s, ex, mant};
  endfunction

  task automatic rand_vec();
    for (int k = 0; k < N; k++) begin
      tv[k] = rand_float();
      if (k > 0 && $urandom_range(0, 3) == 0) tv[k] = tv[$urandom_range(0, k - 1)];
    end
  endtask

  task automatic run_float(input string name, input int stall_grp, input int stall_n,
                           input int dly, input bit spurious, input bit busy_start, input bit do_rst);
    int iss[G], en[G], dn[G];
    int t, done_c, rst_c, last_c, cur, idx;
    logic [31:0] mx;
    logic [31:0] e_in[4], a_in[4];
    logic [3:0]  e_lv;
    bit e_en;
    t = G + 1;
    for (int g = 0; g < G; g++) begin
      iss[g] = t;
      en[g]  = t + ((g == stall_grp) ? stall_n : 0);
      dn[g]  = en[g] + dly;
      t      = dn[g] + 1;
    end
    done_c = t;
    rst_c  = do_rst ? en[1] + 1 : 0;
    last_c = do_rst ? rst_c + 1 : done_c;
    mx     = model_fmax();

    #1;
    reset = 1'b0;
    bus0.start = 1'b1;
    for (int k = 0; k < N; k++) bus0.in_vector[k*32 +: 32] = tv[k];
    bus0.exp_ready = 1'b1;
    bus0.dp_done   = 1'b0;
    #1;
    total++;
    if (bus0.busy !== 1'b0) begin
      bad++;
      $display("FAIL %s idle_busy c=0 got=%b exp=0", name, bus0.busy);
    end
    @(posedge clk);

    for (int c = 1; c <= last_c; c++) begin
      #1;
      bus0.start = busy_start && (c % 3 == 1) && (c < done_c) && (c < last_c);
      if (bus0.start) for (int k = 0; k < N; k++) bus0.in_vector[k*32 +: 32] = $urandom;
      bus0.exp_ready = 1'b1;
      bus0.dp_done   = 1'b0;
      for (int g = 0; g < G; g++) begin
        if (c >= iss[g] && c < en[g]) bus0.exp_ready = 1'b0;
        if (c == dn[g]) bus0.dp_done = 1'b1;
        if (spurious && c >= iss[g] && c <= en[g]) bus0.dp_done = 1'b1;
      end
      reset = (c == rst_c);
      #1;
      if (do_rst && c == last_c) begin
        total++;
        if ({bus0.busy, bus0.dp_enable, bus0.done, bus0.last_group, bus0.lane_valid, bus0.group_idx} !== 9'd0) begin
          bad++;
          $display("FAIL %s rst_ctrl got=%b exp=0", name,
                   {bus0.busy, bus0.dp_enable, bus0.done, bus0.last_group, bus0.lane_valid, bus0.group_idx});
        end
        total++;
        if ({bus0.dp_in1, bus0.dp_in2, bus0.dp_in3, bus0.dp_in4, bus0.dp_max} !== 160'd0) begin
          bad++;
          $display("FAIL %s rst_data got=%h exp=0", name,
                   {bus0.dp_in1, bus0.dp_in2, bus0.dp_in3, bus0.dp_in4, bus0.dp_max});
        end
      end else begin
        e_en = 1'b0;
        cur  = -1;
        for (int g = 0; g < G; g++) begin
          if (c == en[g]) e_en = 1'b1;
          if (c >= iss[g] && c <= dn[g]) cur = g;
        end
        total++;
        if (bus0.dp_enable !== e_en) begin
          bad++;
          $display("FAIL %s dp_enable c=%0d got=%b exp=%b", name, c, bus0.dp_enable, e_en);
        end
        total++;
        if (bus0.done !== (c == done_c)) begin
          bad++;
          $display("FAIL %s done c=%0d got=%b exp=%b", name, c, bus0.done, (c == done_c));
        end
        total++;
        if (bus0.busy !== 1'b1) begin
          bad++;
          $display("FAIL %s busy c=%0d got=%b exp=1", name, c, bus0.busy);
        end
        if (cur >= 0) begin
          for (int l = 0; l < 4; l++) begin
            idx     = 4 * cur + l;
            e_lv[l] = (idx < N);
            e_in[l] = (idx < N) ? tv[idx] : mx;
          end
          a_in[0] = bus0.dp_in1;
          a_in[1] = bus0.dp_in2;
          a_in[2] = bus0.dp_in3;
          a_in[3] = bus0.dp_in4;
          total++;
          if (bus0.dp_max !== mx) begin
            bad++;
            $display("FAIL %s dp_max c=%0d got=%h exp=%h", name, c, bus0.dp_max, mx);
          end
          total++;
          if (bus0.group_idx !== 2'(cur) || bus0.last_group !== (cur == G - 1)) begin
            bad++;
            $display("FAIL %s group c=%0d got=%0d/%b exp=%0d/%b", name, c, bus0.group_idx,
                     bus0.last_group, cur, (cur == G - 1));
          end
          total++;
          if (bus0.lane_valid !== e_lv) begin
            bad++;
            $display("FAIL %s lane_valid c=%0d got=%b exp=%b", name, c, bus0.lane_valid, e_lv);
          end
          for (int l = 0; l < 4; l++) begin
            total++;
            if (a_in[l] !== e_in[l]) begin
              bad++;
              $display("FAIL %s dp_in%0d c=%0d got=%h exp=%h", name, l + 1, c, a_in[l], e_in[l]);
            end
          end
        end
      end
      @(posedge clk);
    end
  endtask

  task automatic run_fixed(input string name);
    logic [31:0] mx;
    mx = model_smax();
    #1;
    reset = 1'b0;
    bus1.start = 1'b1;
    for (int k = 0; k < NF; k++) bus1.in_vector[k*32 +: 32] = tf[k];
    bus1.exp_ready = 1'b1;
    bus1.dp_done   = 1'b0;
    #1;
    @(posedge clk);
    for (int c = 1; c <= 5; c++) begin
      #1;
      bus1.start   = 1'b0;
      bus1.dp_done = (c == 3);
      #1;
      total++;
      if (bus1.dp_enable !== (c == 2) || bus1.done !== (c == 4) || bus1.busy !== (c <= 4)) begin
        bad++;
        $display("FAIL %s ctrl c=%0d got=en%b/done%b/busy%b exp=en%b/done%b/busy%b", name, c,
                 bus1.dp_enable, bus1.done, bus1.busy, (c == 2), (c == 4), (c <= 4));
      end
      if (c == 2 || c == 3) begin
        total++;
        if (bus1.dp_max !== mx) begin
          bad++;
          $display("FAIL %s dp_max c=%0d got=%h exp=%h", name, c, bus1.dp_max, mx);
        end
        total++;
        if (bus1.lane_valid !== 4'hF || bus1.last_group !== 1'b1 ||
            {bus1.dp_in1, bus1.dp_in2, bus1.dp_in3, bus1.dp_in4} !== {tf[0], tf[1], tf[2], tf[3]}) begin
          bad++;
          $display("FAIL %s lanes c=%0d got=%b/%b/%h exp=1111/1/%h", name, c, bus1.lane_valid,
                   bus1.last_group, {bus1.dp_in1, bus1.dp_in2, bus1.dp_in3, bus1.dp_in4},
                   {tf[0], tf[1], tf[2], tf[3]});
        end
      end
      @(posedge clk);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus0.start = 1'b0; bus0.in_vector = '0; bus0.exp_ready = 1'b0; bus0.dp_done = 1'b0;
    bus1.start = 1'b0; bus1.in_vector = '0; bus1.exp_ready = 1'b0; bus1.dp_done = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if ({bus0.busy, bus0.dp_enable, bus0.done, bus0.last_group, bus0.lane_valid, bus0.group_idx,
         bus0.dp_in1, bus0.dp_in2, bus0.dp_in3, bus0.dp_in4, bus0.dp_max} !== 169'd0) begin
      bad++;
      $display("FAIL reset outputs got=%h exp=0",
               {bus0.busy, bus0.dp_enable, bus0.done, bus0.last_group, bus0.lane_valid, bus0.group_idx,
                bus0.dp_in1, bus0.dp_in2, bus0.dp_in3, bus0.dp_in4, bus0.dp_max});
    end
    total++;
    if ({bus1.busy, bus1.done, bus1.dp_max} !== 34'd0) begin
      bad++;
      $display("FAIL reset fixed got=%h exp=0", {bus1.busy, bus1.done, bus1.dp_max});
    end
  endtask

  task automatic test_directed_max();
    for (int k = 0; k < N; k++) tv[k] = 32'h3F800000;
    tv[7] = 32'h40B00000;
    run_float("directed", -1, 0, 1, 1'b0, 1'b0, 1'b0);
    #1;
    total++;
    if (bus0.busy !== 1'b0 || bus0.dp_max !== 32'h40B00000) begin
      bad++;
      $display("FAIL held_max got=%b/%h exp=0/40b00000", bus0.busy, bus0.dp_max);
    end
  endtask

  task automatic test_negative();
    for (int k = 0; k < N; k++) tv[k] = 32'hC0400000;
    tv[1] = 32'hBF000000;
    tv[2] = 32'hC0000000;
    run_float("negative", -1, 0, 1, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_signed_zero();
    for (int k = 0; k < N; k++) tv[k] = (k % 3 == 0) ? 32'h80000000 : 32'h00000000;
    run_float("zeros", -1, 0, 1, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_ready_stall();
    rand_vec();
    run_float("ready_stall", 1, 5, 1, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_delayed_done();
    rand_vec();
    run_float("late_done", -1, 0, 3, 1'b1, 1'b1, 1'b0);
  endtask

  task automatic test_reset_midway();
    rand_vec();
    run_float("mid_reset", -1, 0, 1, 1'b0, 1'b0, 1'b1);
    rand_vec();
    run_float("after_reset", -1, 0, 1, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 6; i++) begin
      rand_vec();
      run_float("b2b", $urandom_range(0, G - 1), $urandom_range(0, 3), $urandom_range(1, 3),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
    end
  endtask

  task automatic test_fixed();
    tf[0] = 32'd5; tf[1] = 32'hFFFFFFF9; tf[2] = 32'd12; tf[3] = 32'd12;
    run_fixed("fixed_dir");
    for (int i = 0; i < 3; i++) begin
      for (int k = 0; k < NF; k++) tf[k] = $urandom;
      run_fixed("fixed_rand");
    end
  endtask

  initial begin
    test_reset();
    test_directed_max();
    test_negative();
    test_signed_zero();
    test_ready_stall();
    test_delayed_done();
    test_reset_midway();
    test_back_to_back();
    test_fixed();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/softmax_exp_input_scheduler.md
# softmax_exp_input_scheduler

Sequencer for the softmax exp-input stage. It accepts a vector of N_INPUTS operands, finds their maximum over several cycles, and feeds the 4-lane "max minus x" subtract datapath one group of four operands at a time. It sits between the softmax top-level control and the exp-input datapath. It drives that datapath's softmax_enable, in1..in4 and max_input ports, and uses the datapath's start_exp as its per-group completion strobe.

## Interface
- ARITH_TYPE, 0: operand format; 0 = IEEE-style float (1/E/M), 1 = two's-complement fixed point
- DATA_WIDTH, 32: operand width
- E, 8: exponent width (ARITH_TYPE 0)
- M, 23: mantissa width (ARITH_TYPE 0)
- N_INPUTS, 10: operands per softmax vector, ≥1; G = ceil(N_INPUTS/4) groups
- clk  in  1  single clock, rising edge
- reset  in  1  synchronous, active-high
- start  in  1  begin new vector; sampled only in IDLE
- in_vector  in  N_INPUTS*DATA_WIDTH  operand k at bits [k*DATA_WIDTH +: DATA_WIDTH]; captured on accepted start
- exp_ready  in  1  exp stage can accept a group
- dp_done  in  1  datapath start_exp; group result registered
- busy  out  1  high in every state except IDLE
- dp_enable  out  1  to datapath softmax_enable; single-cycle pulse per group
- dp_in1..dp_in4  out  DATA_WIDTH each  operands of current group (lane 1 = lowest index)
- dp_max  out  DATA_WIDTH  vector maximum, to datapath max_input
- lane_valid  out  4  valid lanes of current group
- group_idx  out  max(1,$clog2(G))  current group number
- last_group  out  1  current group is group G-1
- done  out  1  one-cycle pulse, vector finished

## Operation
- Reset (synchronous): state IDLE. All outputs are 0, including the internal vector copy and the running max.
- IDLE: start=1 captures in_vector into internal registers and moves to MAX with group counter 0. start=0 stays in IDLE.
- MAX: one group per cycle for G cycles.
  - The running max is seeded with operand 0.
  - Each cycle compares the valid lanes of group g against the running max.
  - After group G-1, dp_max is loaded and the block moves to ISSUE with group 0.
- Compare, ARITH_TYPE 0:
  - If signs differ, the positive operand is greater.
  - Both positive: the larger {exp,mant} is greater.
  - Both negative: the smaller {exp,mant} is greater.
  - +0 and -0 compare equal; on a tie the running max is kept.
  - NaN and Inf are unsupported.
- Compare, ARITH_TYPE 1: signed compare.
- ISSUE: dp_in1..4, lane_valid, group_idx and last_group are registered on entry.
  - Invalid lanes (past N_INPUTS-1) are driven with dp_max, so the subtract yields 0.
  - While exp_ready=0: stay in ISSUE, dp_enable=0.
  - When exp_ready=1: dp_enable=1 for this cycle, then move to WAIT.
- WAIT: operands and dp_max are held stable.
  - dp_done=1: if last_group, go to DONE; otherwise increment the group and go to ISSUE.
  - dp_done=0: stay in WAIT. There is no timeout.
- DONE: done=1 for one cycle, then IDLE. dp_max stays held until the next accepted start.
- start outside IDLE is ignored. dp_done outside WAIT is ignored.
- Reset mid-operation: IDLE on the next edge and all outputs 0. A partially issued vector is abandoned.

## Timing
- Cycle 0 = the IDLE cycle in which start=1 is sampled.
- MAX occupies cycles 1..G; busy=1 from cycle 1.
- dp_max is valid from cycle G+1 onward.
- Datapath contract: dp_done arrives exactly 1 cycle after dp_enable. The block tolerates any larger delay.
- With exp_ready held high, group g occupies two cycles:
  - ISSUE at cycle G+1+2g, with dp_enable high.
  - WAIT at cycle G+2+2g, with dp_done expected.
- done pulses at cycle 3G+1, then IDLE at 3G+2; busy falls at 3G+2. For N_INPUTS=10: done at cycle 10.
- Each cycle with exp_ready low in ISSUE adds one cycle to every later event.
- A back-to-back start is accepted in the first IDLE cycle after done.

## Test plan
- N=10, ARITH_TYPE 0, operands 0x3F800000 (1.0) ×9 and 0x40B00000 (5.5) at index 7, exp_ready=1, dp_done = dp_enable delayed 1 → dp_max=0x40B00000 from cycle 4; dp_enable at cycles 4, 6, 8; lane_valid 1111, 1111, 0011; group 2 lanes 3–4 = 0x40B00000; done at cycle 10.
- All-negative vector: -3.0 (0xC0400000), -0.5 (0xBF000000), -2.0 (0xC0000000), rest -3.0 → dp_max=0xBF000000; a mix of +0 (0x00000000) and -0 (0x80000000) only → dp_max equals operand 0.
- exp_ready low for 5 cycles in group-1 ISSUE → dp_enable stays 0 and operands are stable; the pulse occurs on the first ready cycle; done is delayed by exactly 5 cycles.
- dp_done delayed 3 cycles; start pulsed while busy; spurious dp_done in ISSUE → operands held through WAIT; start ignored; no group skipped; done still occurs once.
- reset asserted in WAIT of group 1 → the next cycle shows IDLE with all outputs 0; a new start then runs a full vector correctly.
- ARITH_TYPE 1, N=4, operands 5, -7, 12, 12 → dp_max=12; one group; done at cycle 4.
